// File: rtl/execute_condition_stage.sv
// ID/EX control register plus conditional-execution unit.
// Owns the NZCV flags and gates E-stage side effects by condition.
module execute_condition_stage #(
    parameter int         RA_W      = 4,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            PCSrcD,
    input  logic            RegWriteD,
    input  logic            MemToRegD,
    input  logic            MemWriteD,
    input  logic            BranchD,
    input  logic            ALUSrcD,
    input  logic            NoWriteD,
    input  logic [3:0]      ALUControlD,
    input  logic [1:0]      FlagWriteD,
    input  logic [3:0]      CondD,
    input  logic [RA_W-1:0] WA3D,
    input  logic [3:0]      ALUFlags,
    output logic [3:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic            MemToRegE,
    output logic [RA_W-1:0] WA3E,
    output logic            ValidE,
    output logic            CondExE,
    output logic            PCSrcE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            BranchTakenE,
    output logic [3:0]      FlagsE
);

    typedef struct packed {
        logic            pcsrc;
        logic            regwrite;
        logic            memtoreg;
        logic            memwrite;
        logic            branch;
        logic            alusrc;
        logic            nowrite;
        logic [3:0]      aluctl;
        logic [1:0]      flagwrite;
        logic [3:0]      cond;
        logic [RA_W-1:0] wa3;
    } id_ex_t;

    id_ex_t     d;
    id_ex_t     e;
    logic       valid;
    logic [3:0] flags;
    logic       n, z, c, v;

    // Bundle the decode-stage controls into one register image
    always_comb begin
        d           = '0;
        d.pcsrc     = PCSrcD;
        d.regwrite  = RegWriteD;
        d.memtoreg  = MemToRegD;
        d.memwrite  = MemWriteD;
        d.branch    = BranchD;
        d.alusrc    = ALUSrcD;
        d.nowrite   = NoWriteD;
        d.aluctl    = ALUControlD;
        d.flagwrite = FlagWriteD;
        d.cond      = CondD;
        d.wa3       = WA3D;
    end

    // ID/EX register: reset and flush insert a bubble, stall holds
    always_ff @(posedge clk) begin
        if (!reset) begin
            e     <= '0;
            valid <= 1'b0;
        end else if (FlushE) begin
            e     <= '0;
            valid <= 1'b0;
        end else if (!StallE) begin
            e     <= d;
            valid <= 1'b1;
        end
    end

    assign {n, z, c, v} = flags;

    // Condition evaluation against the flags held before this edge
    always_comb begin
        CondExE = 1'b0;
        unique case (e.cond)
            4'b0000: CondExE = z;
            4'b0001: CondExE = ~z;
            4'b0010: CondExE = c;
            4'b0011: CondExE = ~c;
            4'b0100: CondExE = n;
            4'b0101: CondExE = ~n;
            4'b0110: CondExE = v;
            4'b0111: CondExE = ~v;
            4'b1000: CondExE = c & ~z;
            4'b1001: CondExE = ~c | z;
            4'b1010: CondExE = (n == v);
            4'b1011: CondExE = (n != v);
            4'b1100: CondExE = ~z & (n == v);
            4'b1101: CondExE = z | (n != v);
            4'b1110: CondExE = 1'b1;
            4'b1111: CondExE = 1'b0;
        endcase
    end

    // Flags commit only when the E instruction retires this edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags <= FLAGS_RST;
        end else if (!FlushE && !StallE && valid && CondExE) begin
            if (e.flagwrite[1]) flags[3:2] <= ALUFlags[3:2];
            if (e.flagwrite[0]) flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign ALUControlE  = e.aluctl;
    assign ALUSrcE      = e.alusrc;
    assign MemToRegE    = e.memtoreg;
    assign WA3E         = e.wa3;
    assign ValidE       = valid;
    assign FlagsE       = flags;
    assign PCSrcE       = e.pcsrc & CondExE;
    assign RegWriteE    = e.regwrite & CondExE & ~e.nowrite;
    assign MemWriteE    = e.memwrite & CondExE;
    assign BranchTakenE = e.branch & CondExE;

endmodule
